// File: rtl/adc_scan_sequencer_pkg.sv
// rtl/adc_scan_sequencer_pkg.sv - shared motor-control types for the ADC scan sequencer
package adc_scan_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_STORE  = 3'd4
    } scanState_t;

    localparam logic CH_ASSIST = 1'b0;
    localparam logic CH_PHASE  = 1'b1;

    typedef logic [11:0] sample_t;

endpackage

// File: rtl/adc_scan_sequencer_tick.sv
// rtl/adc_scan_sequencer_tick.sv - free-running control-loop update strobe divider
module update_tick_gen #(
    parameter int UPDATE_DIV = 128
) (
    input  logic clk,
    input  logic reset,
    input  logic qualify,
    output logic tick
);

    localparam int CW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(UPDATE_DIV - 1);

    logic [CW-1:0] clkCount;

    // Tick lands in the cycle the counter reads 0, gated by the qualifier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkCount <= '0;
            tick     <= 1'b0;
        end else begin
            clkCount <= (clkCount == LAST) ? '0 : clkCount + 1'b1;
            tick     <= (clkCount == LAST) && qualify;
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - alternating two-channel ADC scan with settle, timeout and update tick
module adc_scan_sequencer
    import adc_scan_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int UPDATE_DIV     = 128
) (
    input  logic        c20k,
    input  logic        reset,
    input  logic        enable,
    input  logic        adc_done,
    input  logic [11:0] adc_data,
    output logic        adc_ch,
    output logic        adc_start,
    output logic [11:0] assist_req,
    output logic [11:0] phase_v,
    output logic        data_ready,
    output logic        ctrl_tick,
    output logic        timeout_err
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [SW-1:0] SETTLE_LOAD  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    scanState_t    state;
    logic [SW-1:0] settleCnt;
    logic [TW-1:0] timeoutCnt;
    sample_t       capture;
    logic          goodSample;
    logic          validAssist;
    logic          validPhase;

    assign adc_start  = (state == ST_START);
    assign data_ready = validAssist & validPhase;

    always_ff @(posedge c20k or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            settleCnt   <= '0;
            timeoutCnt  <= '0;
            capture     <= '0;
            goodSample  <= 1'b0;
            validAssist <= 1'b0;
            validPhase  <= 1'b0;
            adc_ch      <= CH_ASSIST;
            assist_req  <= '0;
            phase_v     <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state     <= ST_SETTLE;
                        settleCnt <= SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (settleCnt == '0)
                        state <= ST_START;
                    else
                        settleCnt <= settleCnt - 1'b1;
                end
                ST_START: begin
                    timeoutCnt <= '0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (adc_done) begin
                        capture    <= adc_data;
                        goodSample <= 1'b1;
                        state      <= ST_STORE;
                    end else if (timeoutCnt >= TIMEOUT_LAST) begin
                        timeout_err <= 1'b1;
                        goodSample  <= 1'b0;
                        state       <= ST_STORE;
                    end else if (timeoutCnt != '1) begin
                        timeoutCnt <= timeoutCnt + 1'b1;
                    end
                end
                ST_STORE: begin
                    // A timed-out conversion still advances the scan but leaves the register alone.
                    if (goodSample) begin
                        if (adc_ch == CH_ASSIST) begin
                            assist_req  <= capture;
                            validAssist <= 1'b1;
                        end else begin
                            phase_v    <= capture;
                            validPhase <= 1'b1;
                        end
                    end
                    adc_ch <= ~adc_ch;
                    if (enable) begin
                        state     <= ST_SETTLE;
                        settleCnt <= SETTLE_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    update_tick_gen #(
        .UPDATE_DIV(UPDATE_DIV)
    ) tickGen (
        .clk    (c20k),
        .reset  (reset),
        .qualify(data_ready),
        .tick   (ctrl_tick)
    );

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - directed self-checking bench for adc_scan_sequencer
module tb_adc_scan_sequencer;

    logic        c20k = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        forceDone = 1'b0;
    logic        modelDone = 1'b0;
    logic [11:0] modelData = 12'h000;
    logic        adc_done;
    logic [11:0] adc_data;
    logic        adc_ch;
    logic        adc_start;
    logic [11:0] assist_req;
    logic [11:0] phase_v;
    logic        data_ready;
    logic        ctrl_tick;
    logic        timeout_err;

    int          errors = 0;
    int          checks = 0;
    int          cyc = -1;
    int          startCnt = 0;
    int          tickCnt = 0;
    int          pend = 0;
    logic        pendCh = 1'b0;
    logic        respond0 = 1'b1;
    logic        respond1 = 1'b1;
    logic [11:0] dataCh0 = 12'h800;
    logic [11:0] dataCh1 = 12'h300;

    typedef struct {
        int          cyc;
        logic        en;
        logic        start;
        logic        ch;
        logic [11:0] assist;
        logic [11:0] phase;
        logic        ready;
        logic        tick;
    } vec_t;

    vec_t vecs[$];

    assign adc_done = modelDone | forceDone;
    assign adc_data = forceDone ? 12'hABC : modelData;

    adc_scan_sequencer dut (
        .c20k       (c20k),
        .reset      (reset),
        .enable     (enable),
        .adc_done   (adc_done),
        .adc_data   (adc_data),
        .adc_ch     (adc_ch),
        .adc_start  (adc_start),
        .assist_req (assist_req),
        .phase_v    (phase_v),
        .data_ready (data_ready),
        .ctrl_tick  (ctrl_tick),
        .timeout_err(timeout_err)
    );

    always #5 c20k = ~c20k;

    always @(posedge c20k or posedge reset) begin
        if (reset) cyc <= -1;
        else       cyc <= cyc + 1;
    end

    // ADC model: answers 4 cycles after the start cycle, per-channel enable.
    always @(negedge c20k) begin
        if (!reset && adc_start) startCnt <= startCnt + 1;
        if (!reset && ctrl_tick) tickCnt <= tickCnt + 1;
        if (adc_start) begin
            pendCh    <= adc_ch;
            pend      <= (adc_ch ? respond1 : respond0) ? 4 : 0;
            modelDone <= 1'b0;
        end else if (pend > 0) begin
            pend      <= pend - 1;
            modelDone <= (pend == 1);
            if (pend == 1) modelData <= pendCh ? dataCh1 : dataCh0;
        end else begin
            modelDone <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic gotoCyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge c20k);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL goto: at cycle %0d expected cycle %0d", cyc, n);
        end
    endtask

    task automatic resetDut();
        @(negedge c20k);
        reset = 1'b1;
        repeat (2) @(negedge c20k);
        reset = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_ch"}, {31'd0, adc_ch}, 0);
        check({tag, "_start"}, {31'd0, adc_start}, 0);
        check({tag, "_assist"}, {20'd0, assist_req}, 0);
        check({tag, "_phase"}, {20'd0, phase_v}, 0);
        check({tag, "_ready"}, {31'd0, data_ready}, 0);
        check({tag, "_tick"}, {31'd0, ctrl_tick}, 0);
        check({tag, "_tmo"}, {31'd0, timeout_err}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int snap;

        //           cyc  en    start ch    assist   phase    ready tick
        vecs.push_back('{0,   1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0});
        vecs.push_back('{7,   1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0});
        vecs.push_back('{8,   1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0});
        vecs.push_back('{9,   1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0});
        vecs.push_back('{13,  1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0});
        vecs.push_back('{14,  1'b1, 1'b0, 1'b1, 12'h800, 12'h000, 1'b0, 1'b0});
        vecs.push_back('{22,  1'b1, 1'b1, 1'b1, 12'h800, 12'h000, 1'b0, 1'b0});
        vecs.push_back('{27,  1'b1, 1'b0, 1'b1, 12'h800, 12'h000, 1'b0, 1'b0});
        vecs.push_back('{28,  1'b1, 1'b0, 1'b0, 12'h800, 12'h300, 1'b1, 1'b0});
        vecs.push_back('{36,  1'b1, 1'b1, 1'b0, 12'h800, 12'h300, 1'b1, 1'b0});
        vecs.push_back('{50,  1'b1, 1'b1, 1'b1, 12'h800, 12'h300, 1'b1, 1'b0});
        vecs.push_back('{126, 1'b1, 1'b0, 1'b1, 12'h800, 12'h300, 1'b1, 1'b0});
        vecs.push_back('{127, 1'b1, 1'b0, 1'b1, 12'h800, 12'h300, 1'b1, 1'b1});
        vecs.push_back('{128, 1'b1, 1'b0, 1'b1, 12'h800, 12'h300, 1'b1, 1'b0});
        vecs.push_back('{254, 1'b1, 1'b0, 1'b0, 12'h800, 12'h300, 1'b1, 1'b0});
        vecs.push_back('{255, 1'b1, 1'b0, 1'b0, 12'h800, 12'h300, 1'b1, 1'b1});
        vecs.push_back('{256, 1'b1, 1'b0, 1'b0, 12'h800, 12'h300, 1'b1, 1'b0});

        // Reset state with enable already high, then the nominal scan.
        reset = 1'b1;
        repeat (3) @(negedge c20k);
        checkAllZero("reset");
        reset = 1'b0;
        foreach (vecs[i]) begin
            gotoCyc(vecs[i].cyc);
            enable = vecs[i].en;
            check("scan_start",  {31'd0, adc_start},   {31'd0, vecs[i].start});
            check("scan_ch",     {31'd0, adc_ch},      {31'd0, vecs[i].ch});
            check("scan_assist", {20'd0, assist_req},  {20'd0, vecs[i].assist});
            check("scan_phase",  {20'd0, phase_v},     {20'd0, vecs[i].phase});
            check("scan_ready",  {31'd0, data_ready},  {31'd0, vecs[i].ready});
            check("scan_tick",   {31'd0, ctrl_tick},   {31'd0, vecs[i].tick});
            check("scan_tmo",    {31'd0, timeout_err}, 1'b0);
        end

        // Channel 1 never answers: timeout, phase stays empty, channel 0 still refreshes.
        respond1 = 1'b0;
        resetDut();
        snap = tickCnt;
        gotoCyc(22);
        check("tmo_start_ch1", {31'd0, adc_start}, 1);
        check("tmo_ch1", {31'd0, adc_ch}, 1);
        gotoCyc(100);
        dataCh0 = 12'h5A5;
        gotoCyc(277);
        check("tmo_err_before", {31'd0, timeout_err}, 0);
        gotoCyc(278);
        check("tmo_err_set", {31'd0, timeout_err}, 1);
        check("tmo_ch_store", {31'd0, adc_ch}, 1);
        gotoCyc(279);
        check("tmo_ch_toggle", {31'd0, adc_ch}, 0);
        check("tmo_phase", {20'd0, phase_v}, 0);
        gotoCyc(287);
        check("tmo_start_ch0", {31'd0, adc_start}, 1);
        gotoCyc(293);
        check("tmo_assist_new", {20'd0, assist_req}, 12'h5A5);
        check("tmo_phase_end", {20'd0, phase_v}, 0);
        check("tmo_ready", {31'd0, data_ready}, 0);
        check("tmo_sticky", {31'd0, timeout_err}, 1);
        check("tmo_no_ticks", tickCnt - snap, 0);
        respond1 = 1'b1;
        dataCh0  = 12'h800;

        // Enable dropped right after adc_start: conversion completes, then idle.
        resetDut();
        gotoCyc(8);
        check("drop_start", {31'd0, adc_start}, 1);
        gotoCyc(9);
        enable = 1'b0;
        snap = startCnt;
        gotoCyc(14);
        check("drop_assist", {20'd0, assist_req}, 12'h800);
        check("drop_ch", {31'd0, adc_ch}, 1);
        gotoCyc(60);
        check("drop_no_start", startCnt - snap, 0);
        enable = 1'b1;
        gotoCyc(68);
        check("reen_not_yet", {31'd0, adc_start}, 0);
        gotoCyc(69);
        check("reen_start", {31'd0, adc_start}, 1);
        check("reen_ch", {31'd0, adc_ch}, 1);

        // Spurious adc_done in SETTLE, then reset pulsed mid-WAIT.
        resetDut();
        gotoCyc(3);
        forceDone = 1'b1;
        gotoCyc(4);
        forceDone = 1'b0;
        gotoCyc(5);
        check("spur_assist", {20'd0, assist_req}, 0);
        check("spur_phase", {20'd0, phase_v}, 0);
        check("spur_start", {31'd0, adc_start}, 0);
        gotoCyc(7);
        check("spur_settle_len", {31'd0, adc_start}, 0);
        gotoCyc(8);
        check("spur_start_on_time", {31'd0, adc_start}, 1);
        gotoCyc(14);
        check("spur_assist_real", {20'd0, assist_req}, 12'h800);
        gotoCyc(24);
        check("wait_ch1", {31'd0, adc_ch}, 1);
        reset = 1'b1;
        #1;
        checkAllZero("midreset");
        @(negedge c20k);
        reset = 1'b0;
        gotoCyc(5);
        check("late_done_assist", {20'd0, assist_req}, 0);
        check("late_done_phase", {20'd0, phase_v}, 0);
        gotoCyc(8);
        check("restart_start", {31'd0, adc_start}, 1);
        check("restart_ch0", {31'd0, adc_ch}, 0);
        gotoCyc(14);
        check("restart_assist", {20'd0, assist_req}, 12'h800);
        check("restart_phase", {20'd0, phase_v}, 0);
        check("restart_ready", {31'd0, data_ready}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
